// File: rtl/dcache_ctrl.sv
// dcache_ctrl -- direct-mapped, write-back, write-allocate data cache controller.
//
// 32 lines x 256 bits, each line with valid, dirty and a 22-bit tag.
// Address split: tag [31:10], index [9:5], word [4:2]; bits [1:0] ignored.
// Hits are serviced combinationally. A miss stalls the pipeline, optionally
// writes the dirty victim back, refills the line, then re-evaluates the held
// access in IDLE as a hit.
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-low reset
//   p_addr_i, p_data_i     CPU word address / store data
//   p_MemRead_i/Write_i    load / store request (both high = store)
//   p_data_o               load data (0 unless read hit)
//   p_stall_o              pipeline stall
//   mem_addr_o/data_o      off-chip block address / write-back block
//   mem_enable_o/write_o   off-chip request valid / 1 = write-back
//   mem_data_i, mem_ack_i  off-chip refill block / one-cycle completion
module dcache_ctrl (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  p_addr_i,
    input  logic [31:0]  p_data_i,
    input  logic         p_MemRead_i,
    input  logic         p_MemWrite_i,
    output logic [31:0]  p_data_o,
    output logic         p_stall_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
);

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_e;

    state_e         state_q, state_d;
    logic [31:0]    valid_q, valid_d;
    logic [31:0]    dirty_q, dirty_d;
    logic [31:0]    wb_addr_q, wb_addr_d;
    logic [255:0]   wb_data_q, wb_data_d;
    logic [31:0]    miss_addr_q, miss_addr_d;

    // Tag/data storage is not reset; valid bits gate every use of it.
    logic [21:0]    tag_q  [32];
    logic [255:0]   data_q [32];

    logic           line_we;
    logic [4:0]     line_idx;
    logic [21:0]    line_tag;
    logic [255:0]   line_wdata;

    logic [4:0]     idx;
    logic [7:0]     bit_off;
    logic           access;
    logic           hit;
    logic [255:0]   cur_line;
    logic [31:0]    rd_word;
    logic           unused_addr_lsb;

    assign idx             = p_addr_i[9:5];
    assign bit_off         = {p_addr_i[4:2], 5'b0};
    assign access          = p_MemRead_i | p_MemWrite_i;
    assign cur_line        = data_q[idx];
    assign hit             = valid_q[idx] & (tag_q[idx] == p_addr_i[31:10]);
    assign rd_word         = cur_line[bit_off +: 32];
    assign unused_addr_lsb = ^p_addr_i[1:0];

    assign p_data_o     = (p_MemRead_i & hit) ? rd_word : 32'h0;
    assign p_stall_o    = (access & ~hit) | (state_q != IDLE);
    assign mem_enable_o = (state_q != IDLE);
    assign mem_write_o  = (state_q == WRITEBACK);
    assign mem_addr_o   = (state_q == WRITEBACK) ? wb_addr_q :
                          (state_q == REFILL)    ? miss_addr_q : 32'h0;
    assign mem_data_o   = (state_q == WRITEBACK) ? wb_data_q : 256'h0;

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        miss_addr_d = miss_addr_q;
        line_we     = 1'b0;
        line_idx    = idx;
        line_tag    = p_addr_i[31:10];
        line_wdata  = cur_line;

        case (state_q)
            IDLE: begin
                if (access) begin
                    if (hit) begin
                        // Store hit: merge the word, keep the rest of the line.
                        if (p_MemWrite_i) begin
                            line_we                   = 1'b1;
                            line_wdata[bit_off +: 32] = p_data_i;
                            dirty_d[idx]              = 1'b1;
                        end
                    end else begin
                        miss_addr_d = {p_addr_i[31:5], 5'b0};
                        if (valid_q[idx] & dirty_q[idx]) begin
                            wb_addr_d = {tag_q[idx], idx, 5'b0};
                            wb_data_d = cur_line;
                            state_d   = WRITEBACK;
                        end else begin
                            state_d   = REFILL;
                        end
                    end
                end
            end
            WRITEBACK: begin
                if (mem_ack_i) state_d = REFILL;
            end
            REFILL: begin
                // Install from the latched miss address; the held access
                // then hits on the following IDLE cycle.
                if (mem_ack_i) begin
                    line_we           = 1'b1;
                    line_idx          = miss_addr_q[9:5];
                    line_tag          = miss_addr_q[31:10];
                    line_wdata        = mem_data_i;
                    valid_d[line_idx] = 1'b1;
                    dirty_d[line_idx] = 1'b0;
                    state_d           = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            miss_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            miss_addr_q <= miss_addr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (line_we) begin
            tag_q[line_idx]  <= line_tag;
            data_q[line_idx] <= line_wdata;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

    localparam int LAT = 3;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic [31:0]  p_addr_i = '0;
    logic [31:0]  p_data_i = '0;
    logic         p_MemRead_i = 1'b0;
    logic         p_MemWrite_i = 1'b0;
    logic [31:0]  p_data_o;
    logic         p_stall_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [255:0] mem_data_i = '0;
    logic         mem_ack_i = 1'b0;

    dcache_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .p_addr_i(p_addr_i), .p_data_i(p_data_i),
        .p_MemRead_i(p_MemRead_i), .p_MemWrite_i(p_MemWrite_i),
        .p_data_o(p_data_o), .p_stall_o(p_stall_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } mem_exp_t;

    mem_exp_t     exp_mem[$];
    logic [31:0]  exp_load[$];
    logic [255:0] mem_model [logic [31:0]];
    int           checks = 0;
    int           errors = 0;
    bit           auto_ack = 1'b1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Background memory content: word k of block a = {16'hC0DE, a[15:0]} + k.
    function automatic logic [255:0] pat_blk(input logic [31:0] a);
        logic [255:0] b;
        for (int k = 0; k < 8; k++) b[k*32 +: 32] = {16'hC0DE, a[15:0]} + 32'(k);
        return b;
    endfunction

    function automatic logic [255:0] rd_blk(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return pat_blk(a);
    endfunction

    // Memory responder: ack LAT cycles after a request is seen, one-cycle pulse.
    initial begin
        int  cnt;
        bit  prev;
        cnt = 0;
        forever begin
            @(posedge clk_i); #2;
            if (!auto_ack) cnt = 0;
            else begin
                prev = mem_ack_i;
                mem_ack_i = 1'b0;
                if (prev) cnt = 0;
                if (mem_enable_o && rst_i) begin
                    cnt++;
                    if (cnt >= LAT) begin
                        mem_ack_i = 1'b1;
                        if (mem_write_o) mem_model[mem_addr_o] = mem_data_o;
                        else mem_data_i = rd_blk(mem_addr_o);
                    end
                end else cnt = 0;
            end
        end
    end

    // Monitor: compares every completed memory transfer and every unstalled load.
    initial begin
        mem_exp_t e;
        logic [31:0] l;
        forever begin
            @(negedge clk_i);
            if (rst_i && mem_ack_i && mem_enable_o) begin
                if (exp_mem.size() == 0) chk("unexpected_mem_xfer", {mem_write_o, mem_addr_o}, 0);
                else begin
                    e = exp_mem.pop_front();
                    chk("mem_write", mem_write_o, e.wr);
                    chk("mem_addr", mem_addr_o, e.addr);
                    if (e.wr) chk("mem_wb_data", mem_data_o, e.data);
                end
            end
            if (rst_i && p_MemRead_i && !p_MemWrite_i && !p_stall_o) begin
                if (exp_load.size() == 0) chk("unexpected_load", p_data_o, 0);
                else begin
                    l = exp_load.pop_front();
                    chk("load_data", p_data_o, l);
                end
            end
        end
    end

    task automatic do_access(input string name, input logic [31:0] a, input logic [31:0] d,
                             input bit rd, input bit wr, input int exp_stall);
        int n;
        bit done;
        p_addr_i = a; p_data_i = d; p_MemRead_i = rd; p_MemWrite_i = wr;
        n = 0; done = 0;
        while (!done && n < 100) begin
            @(negedge clk_i);
            if (!p_stall_o) done = 1; else n++;
        end
        if (!done) chk({name, "_timeout"}, 1, 0);
        else chk({name, "_stall_cycles"}, n, exp_stall);
        @(posedge clk_i); #1;
        p_MemRead_i = 0; p_MemWrite_i = 0;
    endtask

    initial begin
        mem_exp_t e;
        logic [255:0] b;
        bit seen;

        b = pat_blk(32'h400);
        b[63:32] = 32'hDEADBEEF;
        mem_model[32'h400] = b;

        repeat (3) @(negedge clk_i);
        chk("rst_stall", p_stall_o, 0);
        chk("rst_pdata", p_data_o, 0);
        chk("rst_enable", mem_enable_o, 0);
        chk("rst_write", mem_write_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_mdata", mem_data_o, 0);
        @(posedge clk_i); #1 rst_i = 1;
        @(posedge clk_i); #1;

        // cold read miss, clean refill
        e = '{0, 32'h400, '0}; exp_mem.push_back(e);
        exp_load.push_back(32'hDEADBEEF);
        do_access("cold_rd", 32'h404, 0, 1, 0, LAT + 1);

        exp_load.push_back(32'hC0DE0402);
        do_access("rd_hit_w2", 32'h408, 0, 1, 0, 0);

        do_access("wr_hit", 32'h404, 32'h12345678, 0, 1, 0);
        exp_load.push_back(32'h12345678);
        do_access("rd_after_wr", 32'h404, 0, 1, 0, 0);

        // write-allocate miss in index 1, word 4
        e = '{0, 32'h2000_0020, '0}; exp_mem.push_back(e);
        do_access("wr_miss", 32'h2000_0030, 32'hCAFEF00D, 0, 1, LAT + 1);
        exp_load.push_back(32'hCAFEF00D);
        do_access("rd_alloc", 32'h2000_0030, 0, 1, 0, 0);
        exp_load.push_back(32'hC0DE0025);
        do_access("rd_alloc_w5", 32'h2000_0034, 0, 1, 0, 0);

        // conflict miss on dirty line: write-back then refill
        b[63:32] = 32'h12345678;
        e = '{1, 32'h400, b}; exp_mem.push_back(e);
        e = '{0, 32'h800, '0}; exp_mem.push_back(e);
        exp_load.push_back(32'hC0DE0801);
        do_access("dirty_miss", 32'h804, 0, 1, 0, 2 * LAT + 1);

        // refetch victim: memory must hold the written-back word
        e = '{0, 32'h400, '0}; exp_mem.push_back(e);
        exp_load.push_back(32'h12345678);
        do_access("refetch", 32'h404, 0, 1, 0, LAT + 1);

        // reset mid-REFILL with a late ack
        auto_ack = 0;
        p_addr_i = 32'h804; p_MemRead_i = 1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_i);
            if (mem_enable_o && !mem_write_o) seen = 1;
        end
        chk("refill_entered", seen, 1);
        chk("refill_addr", mem_addr_o, 32'h800);
        @(posedge clk_i); #1 rst_i = 0;
        #1;
        chk("midrst_enable", mem_enable_o, 0);
        chk("midrst_addr", mem_addr_o, 0);
        p_MemRead_i = 0;
        @(negedge clk_i);
        chk("midrst_stall", p_stall_o, 0);
        chk("midrst_pdata", p_data_o, 0);
        @(posedge clk_i); #1 rst_i = 1;
        @(posedge clk_i); #2 mem_ack_i = 1; mem_data_i = '1;
        @(negedge clk_i);
        chk("late_ack_enable", mem_enable_o, 0);
        chk("late_ack_stall", p_stall_o, 0);
        @(posedge clk_i); #2 mem_ack_i = 0;
        auto_ack = 1;
        @(posedge clk_i); #1;

        e = '{0, 32'h800, '0}; exp_mem.push_back(e);
        exp_load.push_back(32'hC0DE0801);
        do_access("post_rst_miss", 32'h804, 0, 1, 0, LAT + 1);

        repeat (3) @(negedge clk_i);
        chk("mem_queue_drained", exp_mem.size(), 0);
        chk("load_queue_drained", exp_load.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
  clk_i  in  1  clock, all state updates on rising edge
  rst_i  in  1  reset, asynchronous, active-low
  p_addr_i  in  32  CPU byte address from MEM stage
  p_data_i  in  32  CPU store data
  p_MemRead_i  in  1  load request
  p_MemWrite_i  in  1  store request
  p_data_o  out  32  load data to MEM_WB dataMem_data_i
  p_stall_o  out  1  memory stall to all pipeline registers incl. MEM_WB stall_i
  mem_addr_o  out  32  off-chip block address, bits [4:0] = 0
  mem_data_o  out  256  off-chip write-back block
  mem_enable_o  out  1  off-chip request valid
  mem_write_o  out  1  1 = write-back, 0 = refill read
  mem_data_i  in  256  off-chip refill block
  mem_ack_i  in  1  off-chip completion, one-cycle pulse
REQ-002 SHALL use clock clk_i and reset rst_i (asynchronous, active-low).

Function
REQ-003 SHALL be direct-mapped, write-back, write-allocate: 32 lines of 256 bits, each with valid, dirty, 22-bit tag.
REQ-004 SHALL split p_addr_i as tag [31:10], index [9:5], word [4:2]; bits [1:0] ignored (word accesses only).
REQ-005 access = p_MemRead_i | p_MemWrite_i; both high SHALL be treated as a write.
REQ-006 hit = valid[index] & (tag[index] == p_addr_i[31:10]), evaluated combinationally.
REQ-007 p_stall_o SHALL equal (access & ~hit) | (state != IDLE), combinationally.
REQ-008 p_data_o SHALL be the selected word of line[index] when p_MemRead_i & hit, else 32'h0.
REQ-009 Read hit: zero-cycle latency, no stall, no state change.
REQ-010 Write hit: at the clock edge, SHALL write p_data_i into the selected word and set dirty[index]; other words unchanged.
REQ-011 FSM states SHALL be IDLE, WRITEBACK, REFILL.
REQ-012 IDLE, access & ~hit, victim valid & dirty: -> WRITEBACK, latching victim address {victim tag, index, 5'b0} and block.
REQ-013 IDLE, access & ~hit, victim clean or invalid: -> REFILL, latching {p_addr_i[31:5], 5'b0}.
REQ-014 WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o=victim address, mem_data_o=victim block; on mem_ack_i -> REFILL.
REQ-015 REFILL: mem_enable_o=1, mem_write_o=0, mem_addr_o=miss block address; on mem_ack_i SHALL write mem_data_i, tag, valid=1, dirty=0 to the line and -> IDLE.
REQ-016 After REFILL the held access SHALL re-evaluate in IDLE as a hit; stall drops that cycle; a store completes there per REQ-010.
REQ-017 mem_enable_o SHALL remain high, and mem_addr_o/mem_data_o stable, from state entry through the mem_ack_i cycle; 0 in IDLE.
REQ-018 mem_ack_i SHALL be ignored in IDLE.
REQ-019 Miss latency = (write-back ack wait, if dirty) + refill ack wait + 1 IDLE cycle.
REQ-020 CPU inputs SHALL be held stable by the pipeline while p_stall_o=1; the controller SHALL use the latched miss address, not p_addr_i, during WRITEBACK/REFILL.

Reset
REQ-021 On rst_i low (any time, incl. mid-WRITEBACK/REFILL): state=IDLE, all valid and dirty=0, mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0; any in-flight memory transfer is abandoned.
REQ-022 Tag/data arrays need not be reset; p_data_o=0 and p_stall_o=0 while no access is presented after reset.

Verification
REQ-023 Cold read 0x0000_0404, memory acks after 3 cycles with word1=0xDEADBEEF -> stall 1 until IDLE re-entry, REFILL addr 0x0000_0400, mem_write_o=0, then p_data_o=0xDEADBEEF, stall 0.
REQ-024 Read hit same line 0x0000_0408 -> p_data_o = word2 same cycle, stall 0, mem_enable_o stays 0.
REQ-025 Write 0x12345678 to 0x0000_0404 (hit) then read it -> 0x12345678, line dirty, no memory traffic.
REQ-026 Read 0x0000_0804 (same index, other tag) -> WRITEBACK to 0x0000_0400 with word1=0x12345678, then REFILL from 0x0000_0800, then hit.
REQ-027 Assert rst_i low mid-REFILL, late mem_ack_i -> IDLE, mem_enable_o 0, ack ignored, next access to 0x0000_0804 misses.
